// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and raster helpers
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;
  function automatic int raster_total(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH x DEPTH shift register with async reset value; DEPTH 0 is a wire
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_reg
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sr[i] <= RESET_VAL;
      end else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with early coordinates and re-aligned colour/sync
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FRONT    = DEF_H_FRONT,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BACK     = DEF_H_BACK,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FRONT    = DEF_V_FRONT,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BACK     = DEF_V_BACK,
  parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   COLOR_BITS = 4,
  parameter int   PIPE_DELAY = 2,
  parameter int   COUNT_W    = 11
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [COLOR_BITS-1:0] red,
  input  logic [COLOR_BITS-1:0] green,
  input  logic [COLOR_BITS-1:0] blue,
  output logic [COUNT_W-1:0]    pixel_column,
  output logic [COUNT_W-1:0]    pixel_row,
  output logic                  pixel_req,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [COLOR_BITS-1:0] red_out,
  output logic [COLOR_BITS-1:0] green_out,
  output logic [COLOR_BITS-1:0] blue_out,
  output logic                  horiz_sync_out,
  output logic                  vert_sync_out,
  output logic                  video_on
);
  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int MAX_TOTAL = H_TOTAL > V_TOTAL ? H_TOTAL : V_TOTAL;
  localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT  = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT  = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_BEG = COUNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_END = COUNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_BEG = COUNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_END = COUNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  if ((longint'(1) << COUNT_W) <= longint'(MAX_TOTAL)) begin : g_bad_width
    $error("vga_timing_gen: COUNT_W too narrow for raster totals");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be 0..7");
  end
  if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end
  logic [COUNT_W-1:0] h, v;
  logic run, step, h_wrap;
  logic active, hsync, vsync, active_d, hsync_d, vsync_d;
  // run is enable seen at the previous edge: the first enabled cycle shows (0,0) before counting
  assign step   = enable && run;
  assign h_wrap = h == H_LAST;
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      run <= 1'b0;
      h   <= '0;
      v   <= '0;
    end else begin
      run <= enable;
      h   <= step && !h_wrap ? h + 1'b1 : '0;
      v   <= !step ? '0 : !h_wrap ? v : v == V_LAST ? '0 : v + 1'b1;
    end
  assign active       = run && h < H_ACT && v < V_ACT;
  assign hsync        = run && h >= HS_BEG && h < HS_END;
  assign vsync        = run && v >= VS_BEG && v < VS_END;
  assign pixel_column = h;
  assign pixel_row    = v;
  assign pixel_req    = active;
  assign line_start   = run && h == '0;
  assign frame_start  = line_start && v == '0;
  vga_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(3'b000)
  ) u_delay (
    .clk(pixel_clock),
    .rst(reset),
    .d  ({hsync, vsync, active}),
    .q  ({hsync_d, vsync_d, active_d})
  );
  always_ff @(posedge pixel_clock or posedge reset)
    if (reset) begin
      red_out        <= '0;
      green_out      <= '0;
      blue_out       <= '0;
      horiz_sync_out <= sync_level(1'b0, H_SYNC_POL);
      vert_sync_out  <= sync_level(1'b0, V_SYNC_POL);
      video_on       <= 1'b0;
    end else begin
      red_out        <= red & {COLOR_BITS{active_d}};
      green_out      <= green & {COLOR_BITS{active_d}};
      blue_out       <= blue & {COLOR_BITS{active_d}};
      horiz_sync_out <= sync_level(hsync_d, H_SYNC_POL);
      vert_sync_out  <= sync_level(vsync_d, V_SYNC_POL);
      video_on       <= active_d;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random colour/enable/reset stimulus scored against a frame-position model
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;
  localparam int CB = 4, PD = 2, CW = 5, NCYC = 1100;
  localparam logic HPOL = 1'b0, VPOL = 1'b1;
  localparam logic HIDLE = ~HPOL, VIDLE = ~VPOL;
  logic pixel_clock = 1'b0, reset = 1'b0, enable = 1'b1;
  logic [CB-1:0] red = '0, green = '0, blue = '0;
  logic [CW-1:0] pixel_column, pixel_row;
  logic pixel_req, line_start, frame_start;
  logic [CB-1:0] red_out, green_out, blue_out;
  logic horiz_sync_out, vert_sync_out, video_on;
  typedef struct {
    int cyc;
    logic [2*CW+2:0] s0;
    logic [3*CB+2:0] al;
  } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0;
  bit hist_act[2048], hist_hs[2048], hist_vs[2048];
  logic [3*CB-1:0] col_hist[2048];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL),
    .COLOR_BITS(CB), .PIPE_DELAY(PD), .COUNT_W(CW)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset), .enable(enable),
    .red(red), .green(green), .blue(blue),
    .pixel_column(pixel_column), .pixel_row(pixel_row),
    .pixel_req(pixel_req), .line_start(line_start), .frame_start(frame_start),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .horiz_sync_out(horiz_sync_out), .vert_sync_out(vert_sync_out), .video_on(video_on)
  );

  always #5 pixel_clock = ~pixel_clock;
  always @(posedge pixel_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // stimulus: the model tracks the linear position inside the frame and derives h/v from it
  initial begin
    int rst_left, k, p_m, h, v, dis1, dis2, len2;
    bit run_m, rst_next, en, rst_done, a;
    exp_t e;
    rst_left = 3; p_m = 0; run_m = 0; rst_done = 0;
    dis1 = 250 + $urandom_range(0, 60);
    dis2 = 800 + $urandom_range(0, 60);
    len2 = $urandom_range(1, 4);
    #1 reset = 1'b1;
    #1;
    chk("reset_hsync", horiz_sync_out, HIDLE);
    chk("reset_vsync", vert_sync_out, VIDLE);
    chk("reset_colour", {red_out, green_out, blue_out}, 0);
    chk("reset_stage0", {pixel_row, pixel_column, pixel_req, line_start, frame_start}, 0);
    for (int n = 0; n < NCYC; n++) begin
      @(negedge pixel_clock);
      k = cyc;
      // output currently shows the coordinate PD+1 cycles back, i.e. the first hsync pixel
      if (!rst_done && k >= 500 && run_m && p_m % HT == HA + HF + PD + 1) begin
        chk("hsync_before_reset", horiz_sync_out, HPOL);
        reset = 1'b1;
        #1;
        chk("hsync_async_reset", horiz_sync_out, HIDLE);
        chk("colour_async_reset", {red_out, green_out, blue_out}, 0);
        chk("video_on_async_reset", video_on, 0);
        chk("coord_async_reset", {pixel_row, pixel_column, pixel_req}, 0);
        rst_left = 5;
        rst_done = 1;
      end
      rst_next = rst_left > 0;
      if (rst_left > 0) rst_left--;
      en = !((k >= dis1 && k < dis1 + 10) || (k >= dis2 && k < dis2 + len2));
      reset = rst_next;
      enable = en;
      red = CB'($urandom);
      green = CB'($urandom);
      blue = CB'($urandom);
      col_hist[k] = {red, green, blue};
      if (rst_next || !en) begin
        run_m = 0;
        p_m = 0;
      end else begin
        p_m = run_m ? (p_m + 1) % FT : 0;
        run_m = 1;
      end
      h = p_m % HT;
      v = p_m / HT;
      hist_act[k+1] = run_m && h < HA && v < VA;
      hist_hs[k+1]  = run_m && h >= HA + HF && h < HA + HF + HS;
      hist_vs[k+1]  = run_m && v >= VA + VF && v < VA + VF + VS;
      e.cyc = k + 1;
      e.s0 = {CW'(v), CW'(h), hist_act[k+1], run_m && h == 0, run_m && h == 0 && v == 0};
      if (rst_next || k < PD) e.al = {{3*CB{1'b0}}, HIDLE, VIDLE, 1'b0};
      else begin
        a = hist_act[k-PD];
        e.al = {col_hist[k] & {3*CB{a}}, hist_hs[k-PD] ? HPOL : HIDLE, hist_vs[k-PD] ? VPOL : VIDLE, a};
      end
      q.push_back(e);
    end
    repeat (3) @(posedge pixel_clock);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    exp_t m;
    forever begin
      @(posedge pixel_clock);
      #1;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        m = q.pop_front();
        chk("stage0", {pixel_row, pixel_column, pixel_req, line_start, frame_start}, 32'(m.s0));
        chk("aligned", {red_out, green_out, blue_out, horiz_sync_out, vert_sync_out, video_on}, 32'(m.al));
      end
    end
  end
endmodule
